// File: rtl/matrix_inverse_engine.sv
// Sequential Gauss-Jordan inverter for an NxN signed Q(W-FRAC).FRAC matrix, one divider + one multiplier.
// Define MATINV_PIVOT_EN to enable row-swap pivot search on a zero diagonal pivot.
module matrix_inverse_engine #(
    parameter int N    = 5,
    parameter int W    = 16,
    parameter int FRAC = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         busy,
    output logic         done,
    output logic         singular
);
    localparam int NN = N * N;
    localparam int AW = $clog2(NN);
    localparam int QW = W + FRAC;
    localparam int DW = $clog2(QW + 1);
    localparam logic [AW-1:0] NA        = AW'(N);
    localparam logic [AW-1:0] LAST_ROW  = AW'(N - 1);
    localparam logic [AW-1:0] LAST_COL  = AW'(2 * N - 1);
    localparam logic [AW-1:0] LAST_ELEM = AW'(NN - 1);
    localparam logic [DW-1:0] LAST_DIV  = DW'(QW);
    localparam logic signed [2*W:0] SMAX = {{(W+2){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W:0] SMIN = {{(W+2){1'b1}}, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] ONE  = W'(1) << FRAC;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_DIV, S_SEARCH, S_SWAP, S_NORM, S_ELIM, S_UNLOAD
    } state_t;

    state_t state, state_nxt;

    logic signed [W-1:0] a_mem   [NN];
    logic signed [W-1:0] inv_mem [NN];

    logic [AW-1:0] piv, row, col, srow, idx;
    logic [DW-1:0] dcnt;
    logic [W-1:0]  divisor, rem;
    logic [QW-1:0] quo;
    logic          p_neg;
    logic signed [W-1:0] recip, f_reg;

    logic [AW-1:0] ccol, jrow, nrow;
    logic          sel_inv, row_last;
    logic signed [W-1:0] pivot, xi, xj, f_eff, mul_a, wr_val;
    logic signed [2*W-1:0] prod, prod_sh;
    logic [W:0]    shifted, trial;
    logic [W-1:0]  rem_nxt;
    logic [QW-1:0] quo_nxt;
    logic          in_fire, out_fire, fail;

    function automatic logic [AW-1:0] addr(input logic [AW-1:0] r, input logic [AW-1:0] c);
        return r * NA + c;
    endfunction

    function automatic logic signed [W-1:0] sat(input logic signed [2*W:0] v);
        if (v > SMAX) return SMAX[W-1:0];
        if (v < SMIN) return SMIN[W-1:0];
        return v[W-1:0];
    endfunction

    // Quotient is a magnitude; the negative range reaches one further than the positive.
    function automatic logic signed [W-1:0] sat_recip(input logic [QW-1:0] q, input logic neg);
        logic [QW-1:0] lim;
        lim = neg ? (QW'(1) << (W - 1)) : ((QW'(1) << (W - 1)) - QW'(1));
        if (q > lim) return neg ? SMIN[W-1:0] : SMAX[W-1:0];
        return neg ? -$signed(q[W-1:0]) : $signed(q[W-1:0]);
    endfunction

    assign in_ready  = (state == S_LOAD);
    assign out_valid = (state == S_UNLOAD);
    assign busy      = (state != S_IDLE);
    assign out_data  = (state == S_UNLOAD) ? inv_mem[idx] : '0;

    always_comb begin
        sel_inv = (col >= NA);
        ccol    = sel_inv ? col - NA : col;
        jrow    = (state == S_SWAP) ? srow : row;
        pivot   = a_mem[addr(piv, piv)];
        xi      = sel_inv ? inv_mem[addr(piv, ccol)] : a_mem[addr(piv, ccol)];
        xj      = sel_inv ? inv_mem[addr(jrow, ccol)] : a_mem[addr(jrow, ccol)];
        // The row factor is captured before its own column is overwritten.
        f_eff   = (col == '0) ? a_mem[addr(row, piv)] : f_reg;
        mul_a   = (state == S_NORM) ? recip : f_eff;
        prod    = $signed({{W{mul_a[W-1]}}, mul_a}) * $signed({{W{xi[W-1]}}, xi});
        prod_sh = prod >>> FRAC;
        if (state == S_NORM)
            wr_val = sat({prod_sh[2*W-1], prod_sh});
        else
            wr_val = sat({{(W+1){xj[W-1]}}, xj} - {prod_sh[2*W-1], prod_sh});

        shifted = {rem, quo[QW-1]};
        trial   = shifted - {1'b0, divisor};
        rem_nxt = trial[W] ? shifted[W-1:0] : trial[W-1:0];
        quo_nxt = {quo[QW-2:0], ~trial[W]};

        nrow = row + AW'(1);
        if (nrow == piv) nrow = nrow + AW'(1);
        row_last = (nrow >= NA);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fail      = 1'b0;
        in_fire   = (state == S_LOAD) && in_valid;
        out_fire  = (state == S_UNLOAD) && out_ready;
        case (state)
            S_IDLE:   if (start) state_nxt = S_LOAD;
            S_LOAD:   if (in_fire && idx == LAST_ELEM) state_nxt = S_DIV;
            S_DIV: begin
                if (dcnt == '0 && pivot == '0) begin
`ifdef MATINV_PIVOT_EN
                    if (piv == LAST_ROW) begin
                        fail      = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_SEARCH;
                    end
`else
                    fail      = 1'b1;
                    state_nxt = S_IDLE;
`endif
                end else if (dcnt == LAST_DIV) begin
                    state_nxt = S_NORM;
                end
            end
`ifdef MATINV_PIVOT_EN
            S_SEARCH: begin
                if (a_mem[addr(srow, piv)] != '0) begin
                    state_nxt = S_SWAP;
                end else if (srow == LAST_ROW) begin
                    fail      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_SWAP:   if (col == LAST_COL) state_nxt = S_DIV;
`endif
            S_NORM:   if (col == LAST_COL) state_nxt = S_ELIM;
            S_ELIM: begin
                if (col == LAST_COL && row_last)
                    state_nxt = (piv == LAST_ROW) ? S_UNLOAD : S_DIV;
            end
            S_UNLOAD: if (out_fire && idx == LAST_ELEM) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            piv      <= '0;
            row      <= '0;
            col      <= '0;
            srow     <= '0;
            idx      <= '0;
            dcnt     <= '0;
            done     <= 1'b0;
            singular <= 1'b0;
        end else begin
            done <= fail || (out_fire && idx == LAST_ELEM);
            if (fail) singular <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        singular <= 1'b0;
                        idx      <= '0;
                        piv      <= '0;
                        dcnt     <= '0;
                    end
                end
                S_LOAD: if (in_fire) idx <= (idx == LAST_ELEM) ? '0 : idx + AW'(1);
                S_DIV: begin
                    dcnt <= (state_nxt == S_DIV) ? dcnt + DW'(1) : '0;
                    col  <= '0;
                    srow <= piv + AW'(1);
                end
                S_SEARCH: srow <= srow + AW'(1);
                S_SWAP:   col <= (col == LAST_COL) ? '0 : col + AW'(1);
                S_NORM: begin
                    col <= (col == LAST_COL) ? '0 : col + AW'(1);
                    if (col == LAST_COL) row <= (piv == '0) ? AW'(1) : '0;
                end
                S_ELIM: begin
                    if (col == LAST_COL) begin
                        col <= '0;
                        row <= nrow;
                        if (row_last) piv <= piv + AW'(1);
                    end else begin
                        col <= col + AW'(1);
                    end
                end
                S_UNLOAD: if (out_fire) idx <= (idx == LAST_ELEM) ? '0 : idx + AW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && start) begin
            for (int k = 0; k < NN; k++)
                inv_mem[k[AW-1:0]] <= ((k % N) == (k / N)) ? ONE : '0;
        end
        if (in_fire) a_mem[idx] <= in_data;
        // Restoring division of 2^(2*FRAC) by |pivot|: one setup cycle, then one bit per cycle.
        if (state == S_DIV) begin
            if (dcnt == '0) begin
                divisor <= pivot[W-1] ? $unsigned(-pivot) : $unsigned(pivot);
                rem     <= '0;
                quo     <= QW'(1) << (2 * FRAC);
                p_neg   <= pivot[W-1];
            end else begin
                rem <= rem_nxt;
                quo <= quo_nxt;
                if (dcnt == LAST_DIV) recip <= sat_recip(quo_nxt, p_neg);
            end
        end
        if (state == S_NORM) begin
            if (sel_inv) inv_mem[addr(piv, ccol)] <= wr_val;
            else         a_mem[addr(piv, ccol)]   <= wr_val;
        end
        if (state == S_ELIM) begin
            if (col == '0) f_reg <= f_eff;
            if (sel_inv) inv_mem[addr(row, ccol)] <= wr_val;
            else         a_mem[addr(row, ccol)]   <= wr_val;
        end
`ifdef MATINV_PIVOT_EN
        if (state == S_SWAP) begin
            if (sel_inv) begin
                inv_mem[addr(piv, ccol)]  <= xj;
                inv_mem[addr(srow, ccol)] <= xi;
            end else begin
                a_mem[addr(piv, ccol)]  <= xj;
                a_mem[addr(srow, ccol)] <= xi;
            end
        end
`endif
    end

endmodule

// File: tb/tb_matrix_inverse_engine.sv
// Scoreboard bench for matrix_inverse_engine: an N=5 and an N=2 instance share clock and reset.
module tb_matrix_inverse_engine;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start5, in_valid5, in_ready5, out_valid5, out_ready5, busy5, done5, singular5;
    logic [15:0] in_data5, out_data5;
    logic        start2, in_valid2, in_ready2, out_valid2, out_ready2, busy2, done2, singular2;
    logic [15:0] in_data2, out_data2;

    matrix_inverse_engine #(.N(5), .W(16), .FRAC(8)) u_dut5 (
        .clk(clk), .rst(rst), .start(start5), .in_valid(in_valid5), .in_ready(in_ready5),
        .in_data(in_data5), .out_valid(out_valid5), .out_ready(out_ready5), .out_data(out_data5),
        .busy(busy5), .done(done5), .singular(singular5)
    );

    matrix_inverse_engine #(.N(2), .W(16), .FRAC(8)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_data(in_data2), .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .busy(busy2), .done(done2), .singular(singular2)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    int          beats5 = 0;
    int          beats2 = 0;
    logic [15:0] exp5[$];
    logic [15:0] exp2[$];
    logic [15:0] mat5[25];
    logic [15:0] mat2[4];
    logic        hold2 = 1'b0;
    logic [15:0] hold_val2 = 16'h0;
    logic        tog_en = 1'b0;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid5 && out_ready5) begin
            beats5++;
            if (exp5.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL out5_extra: got %h expected no beat", out_data5);
            end else begin
                check("out5_data", out_data5, exp5.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (hold2) begin
                check1("out2_hold_valid", out_valid2, 1'b1);
                check("out2_hold_data", out_data2, hold_val2);
            end
            if (out_valid2 && out_ready2) begin
                beats2++;
                if (exp2.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out2_extra: got %h expected no beat", out_data2);
                end else begin
                    check("out2_data", out_data2, exp2.pop_front());
                end
            end
            hold2     = out_valid2 && !out_ready2;
            hold_val2 = out_data2;
        end
    end

    task automatic load_job(input int which);
        int n;
        n = (which == 5) ? 25 : 4;
        @(posedge clk);
        #1;
        if (which == 5) start5 = 1'b1;
        else            start2 = 1'b1;
        @(posedge clk);
        #1;
        start5 = 1'b0;
        start2 = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (which == 5) begin
                check1("in_ready5", in_ready5, 1'b1);
                in_valid5 = 1'b1;
                in_data5  = mat5[i];
            end else begin
                check1("in_ready2", in_ready2, 1'b1);
                in_valid2 = 1'b1;
                in_data2  = mat2[i];
            end
            @(posedge clk);
            #1;
        end
        in_valid5 = 1'b0;
        in_valid2 = 1'b0;
    endtask

    task automatic wait_done(input int which, input int max_cyc);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < max_cyc && !seen; c++) begin
            @(negedge clk);
            seen = (which == 5) ? done5 : done2;
        end
        check1("done_seen", seen, 1'b1);
        @(negedge clk);
        check1("done_pulse", (which == 5) ? done5 : done2, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   b;
        int   lat;
        int   pulses;
        logic exp_sing;
        rst = 1'b1;
        start5 = 1'b0; in_valid5 = 1'b0; in_data5 = 16'h0; out_ready5 = 1'b1;
        start2 = 1'b0; in_valid2 = 1'b0; in_data2 = 16'h0; out_ready2 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("rst_in_ready", in_ready5, 1'b0);
        check1("rst_out_valid", out_valid5, 1'b0);
        check1("rst_busy", busy5, 1'b0);
        check1("rst_done", done5, 1'b0);
        check1("rst_singular", singular5, 1'b0);
        check("rst_out_data", out_data5, 16'h0000);
        check1("rst_busy2", busy2, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // T4: all-zero matrix is singular, no output beats
        for (int i = 0; i < 25; i++) mat5[i] = 16'h0000;
        b = beats5;
        load_job(5);
        wait_done(5, 200);
        check1("t4_singular", singular5, 1'b1);
        check("t4_no_beats", 16'(beats5 - b), 16'd0);

        // T1: identity; the new start clears the sticky singular flag
        for (int i = 0; i < 25; i++) mat5[i] = (i % 6 == 0) ? 16'h0100 : 16'h0000;
        for (int i = 0; i < 25; i++) exp5.push_back(mat5[i]);
        load_job(5);
        check1("t4_singular_cleared", singular5, 1'b0);
        wait_done(5, 1000);
        check1("t1_singular", singular5, 1'b0);
        check("t1_drained", 16'(exp5.size()), 16'd0);

        // T2: diagonal, compute latency 375 cycles
        for (int i = 0; i < 25; i++) mat5[i] = 16'h0000;
        mat5[0] = 16'h0200; mat5[6] = 16'h0400; mat5[12] = 16'h0800;
        mat5[18] = 16'h1000; mat5[24] = 16'h0100;
        for (int i = 0; i < 25; i++) exp5.push_back(16'h0000);
        exp5[0] = 16'h0080; exp5[6] = 16'h0040; exp5[12] = 16'h0020;
        exp5[18] = 16'h0010; exp5[24] = 16'h0100;
        load_job(5);
        lat = 0;
        repeat (1000) begin
            @(negedge clk);
            if (out_valid5) break;
            lat++;
        end
        check("t2_latency", 16'(lat), 16'd375);
        wait_done(5, 200);
        check1("t2_singular", singular5, 1'b0);
        check("t2_drained", 16'(exp5.size()), 16'd0);

        // T3: 2x2 exact inverse
        mat2[0] = 16'h0200; mat2[1] = 16'h0100; mat2[2] = 16'h0100; mat2[3] = 16'h0100;
        exp2.push_back(16'h0100); exp2.push_back(16'hFF00);
        exp2.push_back(16'hFF00); exp2.push_back(16'h0200);
        load_job(2);
        wait_done(2, 500);
        check1("t3_singular", singular2, 1'b0);
        check("t3_drained", 16'(exp2.size()), 16'd0);

        // T5: same job with a toggling sink
        exp2.push_back(16'h0100); exp2.push_back(16'hFF00);
        exp2.push_back(16'hFF00); exp2.push_back(16'h0200);
        tog_en = 1'b1;
        fork
            begin
                int t;
                t = 0;
                while (tog_en && t < 2000) begin
                    @(posedge clk);
                    #1 out_ready2 = ~out_ready2;
                    t++;
                end
            end
        join_none
        load_job(2);
        wait_done(2, 500);
        tog_en = 1'b0;
        @(posedge clk);
        #2 out_ready2 = 1'b1;
        check("t5_drained", 16'(exp2.size()), 16'd0);

        // T6: zero leading pivot
        mat2[0] = 16'h0000; mat2[1] = 16'h0100; mat2[2] = 16'h0100; mat2[3] = 16'h0000;
`ifdef MATINV_PIVOT_EN
        exp2.push_back(16'h0000); exp2.push_back(16'h0100);
        exp2.push_back(16'h0100); exp2.push_back(16'h0000);
        exp_sing = 1'b0;
`else
        exp_sing = 1'b1;
`endif
        b = beats2;
        load_job(2);
        wait_done(2, 500);
        check1("t6_singular", singular2, exp_sing);
        check("t6_drained", 16'(exp2.size()), 16'd0);
        check("t6_beats", 16'(beats2 - b), exp_sing ? 16'd0 : 16'd4);

        // Reset during the first elimination pass aborts silently
        for (int i = 0; i < 25; i++) mat5[i] = (i % 6 == 0) ? 16'h0100 : 16'h0000;
        load_job(5);
        repeat (50) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check1("abort_busy", busy5, 1'b0);
        check1("abort_done", done5, 1'b0);
        b = beats5;
        pulses = 0;
        repeat (400) begin
            @(negedge clk);
            if (done5) pulses++;
        end
        check("abort_no_done", 16'(pulses), 16'd0);
        check("abort_no_beats", 16'(beats5 - b), 16'd0);
        check1("abort_idle", busy5, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
